// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Round-robin merge of ALU/LSB/BRU results onto one registered CDB.
// Revision : 1.0
// ============================================================================
module cdb_arbiter #(
  parameter int ROB_BITS = 3,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  input  logic                alu_valid,
  input  logic [ROB_BITS-1:0] alu_rob_id,
  input  logic [31:0]         alu_value,
  output logic                alu_ready,
  input  logic                lsb_valid,
  input  logic [ROB_BITS-1:0] lsb_rob_id,
  input  logic [31:0]         lsb_value,
  output logic                lsb_ready,
  input  logic                bru_valid,
  input  logic [ROB_BITS-1:0] bru_rob_id,
  input  logic [31:0]         bru_value,
  output logic                bru_ready,
  output logic                cdb_valid,
  output logic [ROB_BITS-1:0] cdb_rob_id,
  output logic [31:0]         cdb_value,
  output logic [1:0]          cdb_src
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_ENT_W = ROB_BITS + 32;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  logic                     w_live;
  logic [2:0]               w_in_valid;
  logic [2:0][c_ENT_W-1:0]  w_in_data;
  logic [2:0][c_ENT_W-1:0]  w_head;
  logic [2:0]               w_ready;
  logic [2:0]               w_nonempty;
  logic [2:0]               w_push;
  logic [2:0]               w_pop;
  logic                     w_gnt_valid;
  logic [1:0]               w_gnt;
  logic [1:0]               r_rr;

  // Addition modulo 3 for operands in 0..2.
  function automatic logic [1:0] f_add3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  assign w_live     = rdy & ~clear;
  assign w_in_valid = {bru_valid, lsb_valid, alu_valid};
  assign w_in_data  = {{bru_rob_id, bru_value}, {lsb_rob_id, lsb_value}, {alu_rob_id, alu_value}};
  assign alu_ready  = w_ready[0];
  assign lsb_ready  = w_ready[1];
  assign bru_ready  = w_ready[2];

  generate
    for (genvar i = 0; i < 3; i++) begin : g_fifo
      logic [c_ENT_W-1:0] r_mem [DEPTH];
      logic [c_PTR_W-1:0] r_head;
      logic [c_PTR_W-1:0] r_tail;
      logic [c_CNT_W-1:0] r_count;

      assign w_ready[i]    = (r_count != c_DEPTH);
      assign w_nonempty[i] = (r_count != '0);
      assign w_push[i]     = w_in_valid[i] & w_ready[i] & w_live;
      assign w_pop[i]      = w_live & w_gnt_valid & (w_gnt == 2'(i));
      assign w_head[i]     = r_mem[r_head];

      always_ff @(posedge clk) begin
        if (rst || (rdy && clear)) begin
          r_head  <= '0;
          r_tail  <= '0;
          r_count <= '0;
        end else begin
          if (w_push[i]) begin
            r_mem[r_tail] <= w_in_data[i];
            r_tail        <= r_tail + c_PTR_W'(1);
          end
          if (w_pop[i]) begin
            r_head <= r_head + c_PTR_W'(1);
          end
          if (w_push[i] && !w_pop[i]) begin
            r_count <= r_count + c_CNT_W'(1);
          end else if (w_pop[i] && !w_push[i]) begin
            r_count <= r_count - c_CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  // Candidates come from registered counts only, so same-cycle pushes wait a cycle.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!w_gnt_valid && w_nonempty[f_add3(r_rr, 2'(k))]) begin
        w_gnt_valid = 1'b1;
        w_gnt       = f_add3(r_rr, 2'(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      cdb_src    <= 2'd0;
      r_rr       <= 2'd0;
    end else if (rdy) begin
      if (clear) begin
        cdb_valid <= 1'b0;
        r_rr      <= 2'd0;
      end else if (w_gnt_valid) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= w_head[w_gnt][c_ENT_W-1:32];
        cdb_value  <= w_head[w_gnt][31:0];
        cdb_src    <= w_gnt;
        r_rr       <= f_add3(w_gnt, 2'd1);
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Directed self-checking bench for cdb_arbiter (DEPTH=2, ROB_BITS=3).
// Revision : 1.0
// ============================================================================
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        alu_valid, lsb_valid, bru_valid;
  logic [2:0]  alu_rob_id, lsb_rob_id, bru_rob_id;
  logic [31:0] alu_value, lsb_value, bru_value;
  logic        alu_ready, lsb_ready, bru_ready;
  logic        cdb_valid;
  logic [2:0]  cdb_rob_id;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;

  int n_vec = 0;
  int n_err = 0;

  cdb_arbiter #(.ROB_BITS(3), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .clear      (clear),
    .alu_valid  (alu_valid),
    .alu_rob_id (alu_rob_id),
    .alu_value  (alu_value),
    .alu_ready  (alu_ready),
    .lsb_valid  (lsb_valid),
    .lsb_rob_id (lsb_rob_id),
    .lsb_value  (lsb_value),
    .lsb_ready  (lsb_ready),
    .bru_valid  (bru_valid),
    .bru_rob_id (bru_rob_id),
    .bru_value  (bru_value),
    .bru_ready  (bru_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic v, input logic [2:0] rob,
                      input logic [31:0] val, input logic [1:0] src);
    chk({tag, ".valid"}, 64'(cdb_valid), 64'(v));
    if (v) begin
      chk({tag, ".rob"},   64'(cdb_rob_id), 64'(rob));
      chk({tag, ".value"}, 64'(cdb_value),  64'(val));
      chk({tag, ".src"},   64'(cdb_src),    64'(src));
    end
  endtask

  task automatic readies(input string tag);
    chk({tag, ".alu_rdy"}, 64'(alu_ready), 64'd1);
    chk({tag, ".lsb_rdy"}, 64'(lsb_ready), 64'd1);
    chk({tag, ".bru_rdy"}, 64'(bru_ready), 64'd1);
  endtask

  task automatic drive(input int s, input logic v, input logic [2:0] rob, input logic [31:0] val);
    case (s)
      0:       begin alu_valid = v; alu_rob_id = rob; alu_value = val; end
      1:       begin lsb_valid = v; lsb_rob_id = rob; lsb_value = val; end
      default: begin bru_valid = v; bru_rob_id = rob; bru_value = val; end
    endcase
  endtask

  task automatic idle();
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] base [3];
    int          idx  [3];
    logic [2:0]  acc;
    logic [2:0]  vld;
    int          n;
    base = '{32'hA000, 32'hB000, 32'hC000};

    // Reset with all producers offering.
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    drive(0, 1'b1, 3'd1, 32'h11); drive(1, 1'b1, 3'd2, 32'h22); drive(2, 1'b1, 3'd3, 32'h33);
    step();
    chk("rst0.valid", 64'(cdb_valid), 64'd0);
    chk("rst0.rob",   64'(cdb_rob_id), 64'd0);
    chk("rst0.value", 64'(cdb_value), 64'd0);
    chk("rst0.src",   64'(cdb_src), 64'd0);
    readies("rst0");
    step();
    chk("rst1.valid", 64'(cdb_valid), 64'd0);
    readies("rst1");
    rst = 1'b0; idle();
    step();
    chk("post_rst0.valid", 64'(cdb_valid), 64'd0);
    readies("post_rst0");
    step();
    chk("post_rst1.valid", 64'(cdb_valid), 64'd0);

    // Single ALU result.
    drive(0, 1'b1, 3'd5, 32'h1234);
    step();
    idle();
    chk("single.push.valid", 64'(cdb_valid), 64'd0);
    step();
    beat("single.beat", 1'b1, 3'd5, 32'h1234, 2'd0);
    step();
    beat("single.after", 1'b0, 3'd0, 32'd0, 2'd0);

    // Clear brings the round-robin pointer back to alu.
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr0.valid", 64'(cdb_valid), 64'd0);
    readies("clr0");

    // Three-way contention from rr=0.
    drive(0, 1'b1, 3'd1, 32'h0A01); drive(1, 1'b1, 3'd2, 32'h0B02); drive(2, 1'b1, 3'd3, 32'h0C03);
    step();
    idle();
    chk("tri.push.valid", 64'(cdb_valid), 64'd0);
    step(); beat("tri.b0", 1'b1, 3'd1, 32'h0A01, 2'd0);
    step(); beat("tri.b1", 1'b1, 3'd2, 32'h0B02, 2'd1);
    step(); beat("tri.b2", 1'b1, 3'd3, 32'h0C03, 2'd2);
    step(); beat("tri.b3", 1'b0, 3'd0, 32'd0, 2'd0);

    // Back-pressure: every producer streams items 0..4 and retries until accepted.
    // With all three busy, beat n is source n%3, item n/3.
    idx = '{0, 0, 0};
    for (int c = 1; c <= 17; c++) begin
      for (int s = 0; s < 3; s++) begin
        vld[s] = (idx[s] < 5);
        drive(s, vld[s], 3'(idx[s]), base[s] + 32'(idx[s]));
      end
      acc = {bru_ready, lsb_ready, alu_ready};
      step();
      for (int s = 0; s < 3; s++) if (vld[s] && acc[s]) idx[s]++;
      if (c == 1) chk("bp.lsb_rdy_c1", 64'(lsb_ready), 64'd1);
      if (c == 2) chk("bp.lsb_rdy_c2", 64'(lsb_ready), 64'd0);
      if (c >= 2) begin
        n = c - 2;
        if (n < 15) beat($sformatf("bp.b%0d", n), 1'b1, 3'(n / 3), base[n % 3] + 32'(n / 3), 2'(n % 3));
        else        beat("bp.drained", 1'b0, 3'd0, 32'd0, 2'd0);
      end
    end
    idle();
    chk("bp.lsb_accepted", 64'(idx[1]), 64'd5);

    // Flush mid-operation: rr is 1 when clear lands.
    for (int s = 0; s < 3; s++) drive(s, 1'b1, 3'(s + 1), 32'hDEAD0000 + 32'(s));
    step();
    step();
    beat("fl.fill", 1'b1, 3'd1, 32'hDEAD0000, 2'd0);
    idle();
    clear = 1'b1;
    drive(0, 1'b1, 3'd7, 32'h7777);
    step();
    clear = 1'b0;
    chk("fl.clr.valid", 64'(cdb_valid), 64'd0);
    readies("fl.clr");
    drive(0, 1'b1, 3'd4, 32'h4444); drive(1, 1'b1, 3'd5, 32'h5555);
    step();
    idle();
    chk("fl.push.valid", 64'(cdb_valid), 64'd0);
    step(); beat("fl.b0", 1'b1, 3'd4, 32'h4444, 2'd0);
    step(); beat("fl.b1", 1'b1, 3'd5, 32'h5555, 2'd1);
    step(); beat("fl.b2", 1'b0, 3'd0, 32'd0, 2'd0);

    // rdy stall with a beat on the bus.
    drive(2, 1'b1, 3'd6, 32'h6666);
    step();
    idle();
    step();
    beat("st.b0", 1'b1, 3'd6, 32'h6666, 2'd2);
    rdy = 1'b0;
    drive(0, 1'b1, 3'd1, 32'h1111);
    for (int c = 0; c < 3; c++) begin
      step();
      beat($sformatf("st.hold%0d", c), 1'b1, 3'd6, 32'h6666, 2'd2);
      chk($sformatf("st.alu_rdy%0d", c), 64'(alu_ready), 64'd1);
    end
    rdy = 1'b1;
    step();
    idle();
    beat("st.resume", 1'b0, 3'd0, 32'd0, 2'd0);
    step();
    beat("st.b1", 1'b1, 3'd1, 32'h1111, 2'd0);
    step();
    beat("st.b2", 1'b0, 3'd0, 32'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter that merges completion results from the ALU reservation station, the load/store buffer and the branch unit into one registered writeback beat per cycle. It feeds the single completion port of the reorder buffer and the operand-snoop logic of the reservation stations and LSB. Each source has its own small FIFO with back-pressure. Grants rotate round-robin, and the whole block is flushed by the reorder buffer's `clear` (mispredict).

## Interface
- `ROB_BITS`, default 3: width of ROB index (`robsize`).
- `DEPTH`, default 2: entries per source FIFO; power of two, at least 2.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst` input, 1: reset, synchronous, active-high.
- `rdy` input, 1: global enable; when 0 all state holds.
- `clear` input, 1: pipeline flush from the reorder buffer.
- `alu_valid` input, 1: ALU result offered.
- `alu_rob_id` input, ROB_BITS: destination ROB entry of the ALU result.
- `alu_value` input, 32: ALU result value.
- `alu_ready` output, 1: ALU FIFO can accept.
- `lsb_valid`, `lsb_rob_id`, `lsb_value`, `lsb_ready`: same widths and meaning, for the LSB.
- `bru_valid`, `bru_rob_id`, `bru_value`, `bru_ready`: same widths and meaning, for the branch unit; `bru_value[0]` is the taken/predict-correct bit, passed through untouched.
- `cdb_valid` output, 1: broadcast beat valid.
- `cdb_rob_id` output, ROB_BITS: ROB entry being completed.
- `cdb_value` output, 32: result value.
- `cdb_src` output, 2: source of the beat (0 = alu, 1 = lsb, 2 = bru).

## Operation
- Source indices: alu = 0, lsb = 1, bru = 2. Each source has a FIFO with a head pointer, a tail pointer and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- **Push:** `x_ready = (count_x != DEPTH)`.
  - `x_ready` depends on registered count only. It does not look at a same-cycle pop.
  - An entry is written when `x_valid && x_ready && rdy && !clear && !rst`.
  - `x_valid` while `x_ready=0` is not accepted. The producer must hold its result and retry.
- **Arbitration:**
  - Candidates are the non-empty FIFOs, evaluated from registered counts. An entry pushed this cycle is not a candidate until the next cycle.
  - Round-robin pointer `rr` (2 bits, values 0 to 2). Search order is rr, rr+1, rr+2, taken mod 3.
  - The first non-empty source is granted. Its head entry is popped and loaded into the cdb registers. Then `rr` becomes granted+1 mod 3.
  - If no source is non-empty, `cdb_valid` goes to 0, the other cdb fields hold their old values, and `rr` is unchanged.
- **Simultaneous push and pop on one FIFO:** count is unchanged, and both pointers advance.
- **Clear:** when `clear && rdy`, at the edge:
  - all counts and pointers go to 0;
  - `cdb_valid` goes to 0 and `rr` goes to 0;
  - any pushes in that cycle are dropped;
  - the arbitration result of that cycle is discarded.
- **rdy=0:** no push, no pop, `rr` holds, and all cdb outputs hold. Consumers treat the beat as delivered only on an edge with `rdy=1`, so the held beat is delivered exactly once.
- **rst:** same effect as clear, and takes priority over everything. `rdy` is ignored during `rst`.
- **Reset values:**
  - `cdb_valid=0`, `cdb_rob_id=0`, `cdb_value=0`, `cdb_src=0`.
  - `alu_ready`, `lsb_ready`, `bru_ready` all 1, since the counts are 0.
- No reordering within a source: FIFO order is preserved per source. Across sources, order follows the round-robin only.

## Timing
- Latency from accept to beat is 1 cycle minimum. A push accepted at edge N can appear on the cdb after edge N+1.
- Worst-case wait for a head entry is 2 beats (the other two sources each win once). Each source is therefore guaranteed one beat every 3 cycles while it is non-empty.
- Throughput is 1 beat per `rdy` cycle in total.
- `x_ready` is valid combinationally from registers at the start of the cycle.
- The cdb outputs are pure registers, with no combinational path from any input.

## Test plan
- **Reset:**
  - Stimulus: hold `rst=1` for 2 cycles with all valids high, then deassert with valids low.
  - Required: `cdb_valid=0` throughout; all readies =1; no beat ever appears.
- **Single source:**
  - Stimulus: `alu_valid` for 1 cycle with rob_id=5, value=0x1234.
  - Required: on the next cycle, `cdb_valid=1`, `cdb_rob_id=5`, `cdb_value=0x1234`, `cdb_src=0`; on the cycle after, `cdb_valid=0`.
- **Three-way contention:**
  - Stimulus: alu, lsb and bru push rob_ids 1, 2, 3 in the same cycle, from `rr=0`.
  - Required: beats in order rob_id 1, 2, 3 (src 0, 1, 2) on consecutive cycles; `rr` ends at 0.
- **Back-pressure:**
  - Stimulus: lsb pushes continuously (rob_ids 0 to 4) while alu and bru push continuously.
  - Required: `lsb_ready` drops to 0 once the LSB count reaches DEPTH=2; every accepted rob_id is broadcast exactly once, in order; there are no duplicates and no losses.
- **Flush mid-operation:**
  - Stimulus: fill all FIFOs, then assert `clear` for 1 cycle while `alu_valid=1`.
  - Required: on the next cycle `cdb_valid=0` and all readies =1; the ALU push from the clear cycle never appears; the first push after the clear cycle is broadcast with `cdb_src=0`.
- **rdy stall:**
  - Stimulus: a beat rob_id=6 is on the cdb; drop `rdy` for 3 cycles while pushing.
  - Required: outputs hold rob_id=6 throughout the stall; no pushes are accepted; when `rdy` returns, the next beat follows normally.
